// File: rtl/fetch_unit_if.sv
// fetch_unit_if: imem request/response, redirect and
// IF/ID valid/ready signals of the fetch stage.
interface fetch_unit_if;
  logic        o_IMemReqValid;
  logic        i_IMemReqReady;
  logic [31:0] o_IMemReqAddr;
  logic        i_IMemRespValid;
  logic [31:0] i_IMemRespData;
  logic        i_Redirect;
  logic [31:0] i_RedirectPC;
  logic        o_Valid;
  logic        i_Ready;
  logic [31:0] o_InstructionWord;
  logic [31:0] o_PC;
  logic        o_FetchFault;

  modport master (
    output o_IMemReqValid, o_IMemReqAddr,
    output o_Valid, o_InstructionWord,
    output o_PC, o_FetchFault,
    input  i_IMemReqReady, i_IMemRespValid,
    input  i_IMemRespData, i_Redirect,
    input  i_RedirectPC, i_Ready
  );

  modport slave (
    input  o_IMemReqValid, o_IMemReqAddr,
    input  o_Valid, o_InstructionWord,
    input  o_PC, o_FetchFault,
    output i_IMemReqReady, i_IMemRespValid,
    output i_IMemRespData, i_Redirect,
    output i_RedirectPC, i_Ready
  );
endinterface

// File: rtl/fetch_unit.sv
// fetch_unit: owns the PC, issues imem word reads and
// queues returned words in order toward decode.
module fetch_unit #(
  parameter logic [31:0] RESET_PC    = 32'h0000_0000,
  parameter int          QUEUE_DEPTH = 2
) (
  input logic          i_Clock,
  input logic          i_Reset,
  fetch_unit_if.master bus
);
  localparam int AW = $clog2(QUEUE_DEPTH);
  localparam int CW = AW + 1;
  localparam int OW = CW + 2;

  logic [31:0]   pc;
  logic [CW-1:0] outstanding;
  logic [CW-1:0] discard;
  logic [CW-1:0] qcount;
  logic          halted;
  logic [AW-1:0] q_wr;
  logic [AW-1:0] q_rd;
  logic [AW-1:0] pf_wr;
  logic [AW-1:0] pf_rd;
  logic [31:0]   q_word  [QUEUE_DEPTH];
  logic [31:0]   q_pc    [QUEUE_DEPTH];
  logic          q_fault [QUEUE_DEPTH];
  logic [31:0]   pf_mem  [QUEUE_DEPTH];

  logic [OW-1:0] occ;
  logic          req_valid;
  logic          accept;
  logic          resp;
  logic          resp_drop;
  logic          resp_live;
  logic          head_valid;
  logic          consume;
  logic          misalign;

  // every slot counted up front so each response has room
  assign occ = OW'(outstanding) + OW'(discard)
             + OW'(qcount);
  assign req_valid = !i_Reset && !halted
                  && (occ < OW'(QUEUE_DEPTH));
  assign accept = req_valid && bus.i_IMemReqReady;
  assign resp = bus.i_IMemRespValid;
  assign resp_drop = resp && (discard != '0);
  assign resp_live = resp && (discard == '0)
                  && !bus.i_Redirect;
  assign head_valid = (qcount != '0);
  assign consume = head_valid && bus.i_Ready;
  assign misalign = (bus.i_RedirectPC[1:0] != 2'b00);

  assign bus.o_IMemReqValid = req_valid;
  assign bus.o_IMemReqAddr = pc;
  assign bus.o_Valid = head_valid;
  assign bus.o_InstructionWord =
    head_valid ? q_word[q_rd] : 32'h0;
  assign bus.o_PC = head_valid ? q_pc[q_rd] : 32'h0;
  assign bus.o_FetchFault =
    head_valid ? q_fault[q_rd] : 1'b0;

  // pc, counters, pointers and halt; redirect wins
  always_ff @(posedge i_Clock or posedge i_Reset) begin
    if (i_Reset) begin
      pc          <= RESET_PC;
      outstanding <= '0;
      discard     <= '0;
      qcount      <= '0;
      halted      <= 1'b0;
      q_wr        <= '0;
      q_rd        <= '0;
      pf_wr       <= '0;
      pf_rd       <= '0;
    end else if (bus.i_Redirect) begin
      discard <= CW'(OW'(discard) + OW'(outstanding)
               + OW'(accept) - OW'(resp));
      outstanding <= '0;
      pf_wr  <= '0;
      pf_rd  <= '0;
      q_rd   <= '0;
      halted <= misalign;
      if (misalign) begin
        qcount <= CW'(1);
        q_wr   <= AW'(1);
      end else begin
        qcount <= '0;
        q_wr   <= '0;
        pc     <= bus.i_RedirectPC;
      end
    end else begin
      if (accept) begin
        pc    <= pc + 32'd4;
        pf_wr <= pf_wr + AW'(1);
      end
      if (resp_live) begin
        pf_rd <= pf_rd + AW'(1);
        q_wr  <= q_wr + AW'(1);
      end
      if (consume) q_rd <= q_rd + AW'(1);
      if (resp_drop) discard <= discard - CW'(1);
      outstanding <= outstanding + CW'(accept)
                   - CW'(resp_live);
      qcount <= qcount + CW'(resp_live)
              - CW'(consume);
    end
  end

  // entry storage; validity comes from the counters
  always_ff @(posedge i_Clock) begin
    if (accept) pf_mem[pf_wr] <= pc;
    if (bus.i_Redirect && misalign) begin
      q_word[0]  <= 32'h0;
      q_pc[0]    <= bus.i_RedirectPC;
      q_fault[0] <= 1'b1;
    end else if (resp_live) begin
      q_word[q_wr]  <= bus.i_IMemRespData;
      q_pc[q_wr]    <= pf_mem[pf_rd];
      q_fault[q_wr] <= 1'b0;
    end
  end
endmodule
